// File: rtl/execute_stage_fwd.sv
// Execute stage: MEM/WB operand forwarding, gated flags register, shift-add
// multiplier that stalls upstream, and the EX/MEM pipeline register.
module execute_stage_fwd #(
    parameter int DW = 19,
    parameter int PW = 15,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_e,
    input  logic          flush_e,
    input  logic          reg_write_e,
    input  logic          mem_write_e,
    input  logic          result_src_e,
    input  logic          jump_e,
    input  logic          alu_src_e,
    input  logic          set_flags_e,
    input  logic          byte_e,
    input  logic [1:0]    branch_e,
    input  logic [2:0]    alu_control_e,
    input  logic [DW-1:0] rd1_e,
    input  logic [DW-1:0] rd2_e,
    input  logic [DW-1:0] imm_ext_e,
    input  logic [PW-1:0] pc_e,
    input  logic [RW-1:0] rd_e,
    input  logic [1:0]    forward_a_e,
    input  logic [1:0]    forward_b_e,
    input  logic [DW-1:0] result_w,
    output logic          pc_src_e,
    output logic [PW-1:0] pc_target_e,
    output logic          stall_out,
    output logic          reg_write_m,
    output logic          mem_write_m,
    output logic          result_src_m,
    output logic          byte_m,
    output logic [RW-1:0] rd_m,
    output logic [DW-1:0] write_data_m,
    output logic [DW-1:0] alu_result_m,
    output logic [2:0]    flags_o
);
    // state | meaning
    // IDLE  | no multiply in flight; a live mul here stalls and launches
    // BUSY  | one shift-add step per edge, cnt = steps remaining
    // DONE  | product ready; EX/MEM captures it with the held controls
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int SW = $clog2(DW);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [DW-1:0] src_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] src_b;
    logic [DW-1:0] alu_res;
    logic [SW-1:0] shamt;
    logic          alu_v;
    logic          alu_z;
    logic          alu_n;
    logic          is_mul;
    logic          live;
    logic          issue;
    logic          br_taken;

    mul_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [2:0]    flags_q, flags_d;

    logic          reg_write_q, reg_write_d;
    logic          mem_write_q, mem_write_d;
    logic          result_src_q, result_src_d;
    logic          byte_q, byte_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic [DW-1:0] alu_result_q, alu_result_d;

    assign is_mul = (alu_control_e == OP_MUL);
    assign live   = valid_e & ~flush_e;

    // Forwarding from MEM uses the registered EX/MEM result, never the next value.
    always_comb begin
        case (forward_a_e)
            2'b01:   src_a = result_w;
            2'b10:   src_a = alu_result_q;
            default: src_a = rd1_e;
        endcase
        case (forward_b_e)
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = rd2_e;
        endcase
        src_b = alu_src_e ? imm_ext_e : fwd_b;
    end

    always_comb begin
        shamt   = src_b[SW-1:0];
        alu_res = '0;
        alu_v   = 1'b0;
        case (alu_control_e)
            OP_ADD: begin
                alu_res = src_a + src_b;
                alu_v   = (src_a[DW-1] == src_b[DW-1]) && (alu_res[DW-1] != src_a[DW-1]);
            end
            OP_SUB: begin
                alu_res = src_a - src_b;
                alu_v   = (src_a[DW-1] != src_b[DW-1]) && (alu_res[DW-1] != src_a[DW-1]);
            end
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SHL:  alu_res = src_a << shamt;
            OP_SHR:  alu_res = src_a >> shamt;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == '0);
        alu_n = alu_res[DW-1];
    end

    // Branches see only the registered flags, never this instruction's own.
    always_comb begin
        case (branch_e)
            2'b01:   br_taken = ~(flags_q[0] ^ flags_q[1]);
            2'b10:   br_taken = flags_q[0] ^ flags_q[1];
            2'b11:   br_taken = flags_q[2];
            default: br_taken = 1'b0;
        endcase
    end

    assign stall_out   = (state_q == ST_BUSY) | ((state_q == ST_IDLE) & live & is_mul);
    assign issue       = live & ~stall_out;
    assign pc_src_e    = issue & (jump_e | br_taken);
    assign pc_target_e = pc_e + imm_ext_e[PW-1:0];

    always_comb begin
        flags_d = flags_q;
        if (issue & set_flags_e & ~is_mul) begin
            flags_d = {alu_z, alu_v, alu_n};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (live & is_mul) begin
                    state_d  = ST_BUSY;
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    acc_d    = '0;
                    cnt_d    = CW'(DW);
                end
            end
            ST_BUSY: begin
                if (flush_e) begin
                    state_d = ST_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A stalled, flushed or empty slot enters MEM as an all-zero bubble.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = 1'b0;
        byte_d       = 1'b0;
        rd_d         = '0;
        write_data_d = '0;
        alu_result_d = '0;
        if (issue) begin
            reg_write_d  = reg_write_e;
            mem_write_d  = mem_write_e;
            result_src_d = result_src_e;
            byte_d       = byte_e;
            rd_d         = rd_e;
            write_data_d = fwd_b;
            alu_result_d = (state_q == ST_DONE) ? acc_q : alu_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            flags_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            byte_q       <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            flags_q      <= flags_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            byte_q       <= byte_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign reg_write_m  = reg_write_q;
    assign mem_write_m  = mem_write_q;
    assign result_src_m = result_src_q;
    assign byte_m       = byte_q;
    assign rd_m         = rd_q;
    assign write_data_m = write_data_q;
    assign alu_result_m = alu_result_q;
    assign flags_o      = flags_q;

endmodule

// File: tb/tb_execute_stage_fwd.sv
// Bench for execute_stage_fwd: directed scenarios then random instructions,
// all compared against an arithmetic reference model of the stage.
module tb_execute_stage_fwd;
    localparam int DW = 19;
    localparam int PW = 15;
    localparam int RW = 5;
    localparam longint MASK  = (longint'(1) << DW) - 1;
    localparam longint PMASK = (longint'(1) << PW) - 1;
    localparam longint SMAX  = (longint'(1) << (DW - 1)) - 1;
    localparam longint SMIN  = -(longint'(1) << (DW - 1));

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_e, flush_e;
    logic          reg_write_e, mem_write_e, result_src_e, jump_e, alu_src_e, set_flags_e, byte_e;
    logic [1:0]    branch_e;
    logic [2:0]    alu_control_e;
    logic [DW-1:0] rd1_e, rd2_e, imm_ext_e, result_w;
    logic [PW-1:0] pc_e;
    logic [RW-1:0] rd_e;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          pc_src_e, stall_out;
    logic [PW-1:0] pc_target_e;
    logic          reg_write_m, mem_write_m, result_src_m, byte_m;
    logic [RW-1:0] rd_m;
    logic [DW-1:0] write_data_m, alu_result_m;
    logic [2:0]    flags_o;

    always #5 clk = ~clk;

    execute_stage_fwd #(.DW(DW), .PW(PW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e), .flush_e(flush_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
        .jump_e(jump_e), .alu_src_e(alu_src_e), .set_flags_e(set_flags_e), .byte_e(byte_e),
        .branch_e(branch_e), .alu_control_e(alu_control_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .rd_e(rd_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .stall_out(stall_out),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .byte_m(byte_m), .rd_m(rd_m), .write_data_m(write_data_m),
        .alu_result_m(alu_result_m), .flags_o(flags_o)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0]    m_flags;
    logic [DW-1:0] m_alu_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint v);
        return (v > SMAX) ? v - (longint'(1) << DW) : v;
    endfunction

    function automatic longint pick(input logic [1:0] sel, input logic [DW-1:0] rf);
        if (sel == 2'b01) return longint'(result_w);
        if (sel == 2'b10) return longint'(m_alu_m);
        return longint'(rf);
    endfunction

    // Branch rules on {Z,V,N}: GE when N equals V, LT when they differ, EQ on Z.
    function automatic logic br_cond(input logic [1:0] br, input logic [2:0] f);
        case (br)
            2'b01:   return f[1] == f[0];
            2'b10:   return f[1] != f[0];
            2'b11:   return f[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 19'h3FFFF;
            1:       return 19'h40000;
            2:       return 19'h7FFFF;
            3:       return '0;
            4:       return DW'($urandom_range(0, 40));
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic clear_instr();
        valid_e = 1'b1; flush_e = 1'b0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; result_src_e = 1'b0; jump_e = 1'b0;
        alu_src_e = 1'b0; set_flags_e = 1'b0; byte_e = 1'b0;
        branch_e = 2'b00; alu_control_e = 3'b000;
        rd1_e = '0; rd2_e = '0; imm_ext_e = '0; pc_e = '0; rd_e = '0;
        forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = '0;
    endtask

    // Entered and left one time unit after a rising edge, inputs already driven.
    task automatic run_instr(input string tag);
        longint a, b, fb, res, full;
        int sh, stalls;
        logic v, live, is_mul, exp_pc;
        logic [2:0] nf;
        a  = pick(forward_a_e, rd1_e);
        fb = pick(forward_b_e, rd2_e);
        b  = alu_src_e ? longint'(imm_ext_e) : fb;
        sh = int'(b % 32);
        v  = 1'b0;
        case (alu_control_e)
            3'd0: begin full = sx(a) + sx(b); v = (full > SMAX) || (full < SMIN); res = a + b; end
            3'd1: begin full = sx(a) - sx(b); v = (full > SMAX) || (full < SMIN); res = a - b; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sh >= DW) ? '0 : (a << sh);
            3'd6: res = (sh >= DW) ? '0 : (a >> sh);
            default: res = a * b;
        endcase
        res = res & MASK;
        nf  = {res == '0, v, ((res >> (DW - 1)) & longint'(1)) == longint'(1)};
        live   = valid_e & ~flush_e;
        is_mul = (alu_control_e == 3'd7);
        exp_pc = live & (jump_e | br_cond(branch_e, m_flags));
        #3;
        check({tag, "_tgt"}, 64'(pc_target_e), (longint'(pc_e) + longint'(imm_ext_e)) & PMASK);
        if (live && is_mul) begin
            check({tag, "_pcsrc_stall"}, 64'(pc_src_e), 64'd0);
            stalls = 0;
            while (stall_out === 1'b1 && stalls < 40) begin
                stalls++;
                @(posedge clk); #1;
                check({tag, "_bubble_rw"}, 64'(reg_write_m), 64'd0);
                #2;
            end
            check({tag, "_stall_cycles"}, 64'(stalls), 64'd20);
            check({tag, "_pcsrc_done"}, 64'(pc_src_e), 64'd0);
        end else begin
            check({tag, "_stall"}, 64'(stall_out), 64'd0);
            check({tag, "_pcsrc"}, 64'(pc_src_e), 64'(exp_pc));
        end
        @(posedge clk); #1;
        if (live) begin
            check({tag, "_res"}, 64'(alu_result_m), res);
            check({tag, "_rw"}, 64'(reg_write_m), 64'(reg_write_e));
            check({tag, "_mw"}, 64'(mem_write_m), 64'(mem_write_e));
            check({tag, "_rs"}, 64'(result_src_m), 64'(result_src_e));
            check({tag, "_byte"}, 64'(byte_m), 64'(byte_e));
            check({tag, "_rd"}, 64'(rd_m), 64'(rd_e));
            check({tag, "_wd"}, 64'(write_data_m), fb);
            m_alu_m = DW'(res);
        end else begin
            check({tag, "_bub_res"}, 64'(alu_result_m), 64'd0);
            check({tag, "_bub_rw"}, 64'(reg_write_m), 64'd0);
            check({tag, "_bub_mw"}, 64'(mem_write_m), 64'd0);
            m_alu_m = '0;
        end
        if (live && set_flags_e && !is_mul) m_flags = nf;
        check({tag, "_flags"}, 64'(flags_o), 64'(m_flags));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res"}, 64'(alu_result_m), 64'd0);
        check({tag, "_wd"}, 64'(write_data_m), 64'd0);
        check({tag, "_rd"}, 64'(rd_m), 64'd0);
        check({tag, "_ctl"}, 64'({reg_write_m, mem_write_m, result_src_m, byte_m}), 64'd0);
        check({tag, "_flags"}, 64'(flags_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_instr();
        valid_e = 1'b0;
        m_flags = '0;
        m_alu_m = '0;
        #12;
        check_all_zero("reset");
        check("reset_stall", 64'(stall_out), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        clear_instr(); rd1_e = 19'h3FFFF; rd2_e = 19'h1; set_flags_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd3;
        run_instr("add_ovf");
        check("add_ovf_val", 64'(alu_result_m), 64'h40000);
        check("add_ovf_zvn", 64'(flags_o), 64'b011);
        clear_instr(); branch_e = 2'b10; pc_e = 15'h0010; imm_ext_e = 19'h8;
        run_instr("blt");
        clear_instr(); branch_e = 2'b01; pc_e = 15'h0010; imm_ext_e = 19'h8;
        run_instr("bge");

        clear_instr(); alu_control_e = 3'd1; rd1_e = 19'd5; rd2_e = 19'd5; set_flags_e = 1'b1;
        run_instr("sub_eq");
        check("sub_eq_zvn", 64'(flags_o), 64'b100);
        clear_instr(); branch_e = 2'b11; imm_ext_e = 19'h20;
        run_instr("beq_taken");
        clear_instr(); alu_control_e = 3'd1; rd1_e = 19'd5; rd2_e = 19'd3; set_flags_e = 1'b1;
        run_instr("sub_ne");
        clear_instr(); alu_control_e = 3'd1; rd1_e = 19'd5; rd2_e = 19'd5;
        run_instr("sub_nosf");
        check("sub_nosf_hold", 64'(flags_o), 64'b000);
        clear_instr(); branch_e = 2'b11; imm_ext_e = 19'h20;
        run_instr("beq_not");

        clear_instr(); rd1_e = 19'h100; rd2_e = 19'h23; reg_write_e = 1'b1;
        run_instr("fwd_src");
        clear_instr(); forward_a_e = 2'b10; imm_ext_e = 19'h10; alu_src_e = 1'b1; reg_write_e = 1'b1;
        run_instr("fwd_mem");
        check("fwd_mem_val", 64'(alu_result_m), 64'h133);
        clear_instr(); forward_b_e = 2'b01; result_w = 19'h7; rd2_e = 19'h55; mem_write_e = 1'b1;
        alu_src_e = 1'b1; imm_ext_e = 19'h4;
        run_instr("fwd_wb_store");
        check("fwd_wb_store_wd", 64'(write_data_m), 64'h7);

        clear_instr(); rd1_e = 19'h3FFFF; rd2_e = 19'h1; set_flags_e = 1'b1;
        run_instr("pre_mul_flags");
        clear_instr(); alu_control_e = 3'd7; rd1_e = 19'd300; rd2_e = 19'd500; reg_write_e = 1'b1; rd_e = 5'd9;
        set_flags_e = 1'b1;
        run_instr("mul");
        check("mul_val", 64'(alu_result_m), 64'h249F0);
        check("mul_flags_kept", 64'(flags_o), 64'b011);

        clear_instr(); alu_control_e = 3'd7; rd1_e = 19'd1234; rd2_e = 19'd77; reg_write_e = 1'b1; rd_e = 5'd4;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        flush_e = 1'b1; #3;
        check("fl_busy_stall", 64'(stall_out), 64'd1);
        check("fl_busy_pcsrc", 64'(pc_src_e), 64'd0);
        @(posedge clk); #1;
        flush_e = 1'b0; valid_e = 1'b0; #1;
        check("fl_idle_stall", 64'(stall_out), 64'd0);
        check("fl_bub_rw", 64'(reg_write_m), 64'd0);
        repeat (25) @(posedge clk);
        #1;
        check("fl_no_product_rw", 64'(reg_write_m), 64'd0);
        check("fl_no_product_res", 64'(alu_result_m), 64'd0);
        m_alu_m = '0;

        clear_instr(); flush_e = 1'b1; jump_e = 1'b1; rd1_e = 19'd1; set_flags_e = 1'b1; reg_write_e = 1'b1;
        run_instr("flush_add");

        clear_instr(); alu_control_e = 3'd7; rd1_e = 19'd999; rd2_e = 19'd3; reg_write_e = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("rm_busy_stall", 64'(stall_out), 64'd1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_mul");
        valid_e = 1'b0;
        #2 reset = 1'b1;
        #1 check("rst_mul_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        m_flags = '0; m_alu_m = '0;

        clear_instr(); rd1_e = 19'h3FFFF; rd2_e = 19'h1; set_flags_e = 1'b1; reg_write_e = 1'b1;
        mem_write_e = 1'b1; byte_e = 1'b1; rd_e = 5'd7; rd2_e = 19'h1;
        run_instr("pre_rst");
        #2 reset = 1'b0;
        #1 check_all_zero("rst_stream");
        valid_e = 1'b0;
        #2 reset = 1'b1;
        #1 check("rst_stream_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        m_flags = '0; m_alu_m = '0;

        for (int i = 0; i < 250; i++) begin
            valid_e       = ($urandom_range(0, 7) != 0);
            flush_e       = ($urandom_range(0, 7) == 0);
            reg_write_e   = 1'($urandom);
            mem_write_e   = 1'($urandom);
            result_src_e  = 1'($urandom);
            byte_e        = 1'($urandom);
            alu_src_e     = 1'($urandom);
            set_flags_e   = 1'($urandom);
            jump_e        = ($urandom_range(0, 5) == 0);
            branch_e      = 2'($urandom);
            alu_control_e = 3'($urandom);
            if (alu_control_e == 3'd7 && $urandom_range(0, 1) == 0) alu_control_e = 3'($urandom_range(0, 6));
            if (alu_control_e == 3'd7) begin jump_e = 1'b0; branch_e = 2'b00; end
            rd1_e       = rnd_val();
            rd2_e       = rnd_val();
            imm_ext_e   = rnd_val();
            result_w    = rnd_val();
            pc_e        = PW'($urandom);
            rd_e        = RW'($urandom);
            forward_a_e = 2'($urandom);
            forward_b_e = 2'($urandom);
            run_instr("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
